// File: rtl/mem_byte_seq_pkg.sv
`default_nettype none
// =============================================================================
// Module : mem_byte_seq_pkg
// Brief  : Shared state/size encodings and byte-count helper for mem_byte_seq.
// Rev    : 1.0  initial release
// =============================================================================
package mem_byte_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Byte counter width: must hold the value 4 (one past the last lane index).
    localparam int CNT_W = 3;

    // Size code 3 is deliberately folded into the word case.
    function automatic logic [CNT_W-1:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return CNT_W'(1);
            SIZE_HALF: return CNT_W'(2);
            default:   return CNT_W'(4);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_seq.sv
`default_nettype none
// =============================================================================
// Module : mem_byte_seq
// Brief  : Splits LB/LH/LW/SB/SH/SW into byte RAM accesses with grant retry,
//          little-endian load assembly and sign/zero extension.
// Rev    : 1.0  initial release
// =============================================================================
module mem_byte_seq
    import mem_byte_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              req_i,
    input  logic              write_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_request_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_write_o,
    output logic [7:0]        mem_wdata_o,
    input  logic              mem_grant_i,
    input  logic [7:0]        ram_din_i
);

    localparam int LANE_W = $clog2(DATA_W / 8);

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic                signed_q, signed_d;
    logic [CNT_W-1:0]    nbytes_q, nbytes_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic                pend_valid_q, pend_valid_d;
    logic [LANE_W-1:0]   pend_idx_q, pend_idx_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   asm_cap;

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                 input logic [CNT_W-1:0]  n,
                                                 input logic              sgn);
        logic [DATA_W-1:0] r;
        logic              fill;
        r    = v;
        fill = sgn & v[8 * int'(n) - 1];
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= 8 * int'(n)) r[i] = fill;
        end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        signed_d     = signed_q;
        nbytes_d     = nbytes_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        idx_d        = idx_q;
        pend_valid_d = pend_valid_q;
        pend_idx_d   = pend_idx_q;
        asm_d        = asm_q;
        rdata_d      = rdata_q;
        done_d       = 1'b0;

        // RAM data arrives one cycle after its granted address.
        asm_cap = asm_q;
        if (pend_valid_q) asm_cap[{pend_idx_q, 3'b000} +: 8] = ram_din_i;

        if (rdy) begin
            asm_d        = asm_cap;
            pend_valid_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        write_d  = write_i;
                        signed_d = signed_i;
                        nbytes_d = size_to_bytes(size_i);
                        addr_d   = addr_i;
                        wdata_d  = wdata_i;
                        idx_d    = '0;
                        asm_d    = '0;
                        state_d  = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_grant_i) begin
                        idx_d = idx_q + CNT_W'(1);
                        if (!write_q) begin
                            pend_valid_d = 1'b1;
                            pend_idx_d   = idx_q[LANE_W-1:0];
                        end
                        if (idx_q + CNT_W'(1) == nbytes_q) begin
                            state_d = write_q ? ST_IDLE : ST_DRAIN;
                            done_d  = write_q;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    rdata_d = extend(asm_cap, nbytes_q, signed_q);
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (pend_valid_q) begin
            // Frozen cycle loses the returning byte: rewind and fetch it again.
            pend_valid_d = 1'b0;
            idx_d        = CNT_W'(pend_idx_q);
            if (state_q == ST_DRAIN) state_d = ST_ISSUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            nbytes_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            idx_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
            asm_q        <= '0;
            rdata_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            signed_q     <= signed_d;
            nbytes_q     <= nbytes_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            idx_q        <= idx_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            asm_q        <= asm_d;
            rdata_q      <= rdata_d;
            done_q       <= done_d;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign rdata_o       = rdata_q;
    assign mem_request_o = (state_q == ST_ISSUE);
    assign mem_write_o   = mem_request_o & write_q;
    assign mem_addr_o    = addr_q + ADDR_W'(idx_q);
    assign mem_wdata_o   = wdata_q[{idx_q[LANE_W-1:0], 3'b000} +: 8];

endmodule
`default_nettype wire

// File: tb/tb_mem_byte_seq.sv
`default_nettype none
// =============================================================================
// Module : tb_mem_byte_seq
// Brief  : Directed plus randomized bench for mem_byte_seq with a RAM model.
// Rev    : 1.0  initial release
// =============================================================================
module tb_mem_byte_seq;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        req_i;
    logic        write_i;
    logic [1:0]  size_i;
    logic        signed_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        mem_request_o;
    logic [31:0] mem_addr_o;
    logic        mem_write_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_grant_i;
    logic [7:0]  ram_din_i;

    mem_byte_seq #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .req_i(req_i), .write_i(write_i),
        .size_i(size_i), .signed_i(signed_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
        .mem_request_o(mem_request_o), .mem_addr_o(mem_addr_o),
        .mem_write_o(mem_write_o), .mem_wdata_o(mem_wdata_o),
        .mem_grant_i(mem_grant_i), .ram_din_i(ram_din_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 64 KiB aliased on the low address bits, plus a backdoor preload.
    logic [7:0]  ram [0:65535];
    logic        bd_we;
    logic [15:0] bd_addr;
    logic [7:0]  bd_data;
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_request_o && mem_grant_i) begin
            if (mem_write_o) ram[mem_addr_o[15:0]] <= mem_wdata_o;
            else             ram_din_i <= ram[mem_addr_o[15:0]];
        end
    end

    logic [7:0]  ref_mem [0:65535];
    int          checks;
    int          errors;
    logic        log_req  [64];
    logic        log_wr   [64];
    logic [31:0] log_addr [64];
    logic [7:0]  log_wd   [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Reference load result: little-endian bytes, then extend by arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb, input bit sg);
        longint unsigned v;
        logic [31:0]     ak;
        v = 0;
        for (int k = 0; k < nb; k++) begin
            ak = a + k;
            v  = v | (longint'(ref_mem[ak[15:0]]) << (8 * k));
        end
        if (sg && v[8 * nb - 1]) v = v - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    // Issues one request in cycle 0 and logs cycles 1.. until done_o (bounded).
    task automatic run_op(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [63:0] gnt_low, input logic [63:0] rdy_low,
                          output int done_cyc, output logic [31:0] rd);
        for (int c = 0; c < 64; c++) begin
            log_req[c] = 1'b0; log_wr[c] = 1'b0; log_addr[c] = '0; log_wd[c] = '0;
        end
        done_cyc = -1;
        rd       = '0;
        @(posedge clk); #1;
        req_i = 1'b1; write_i = wr; size_i = sz; signed_i = sg; addr_i = a; wdata_i = wd;
        rdy = 1'b1; mem_grant_i = ~gnt_low[0];
        for (int c = 1; c < 64 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            req_i = 1'b0; rdy = ~rdy_low[c]; mem_grant_i = ~gnt_low[c];
            @(negedge clk);
            log_req[c]  = mem_request_o;
            log_wr[c]   = mem_write_o;
            log_addr[c] = mem_addr_o;
            log_wd[c]   = mem_wdata_o;
            if (done_o) begin
                done_cyc = c;
                rd       = rdata_o;
            end
        end
        rdy = 1'b1;
        if (done_cyc < 0) check("done_timeout", 32'(done_cyc), 32'd0);
    endtask

    initial begin
        int          dc;
        logic [31:0] rd;
        checks = 0; errors = 0;
        rst = 1'b1; rdy = 1'b1; req_i = 1'b0; write_i = 1'b0; size_i = '0; signed_i = 1'b0;
        addr_i = '0; wdata_i = '0; mem_grant_i = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        @(posedge clk); #1;
        poke(16'h1000, 8'h78); poke(16'h1001, 8'h56); poke(16'h1002, 8'h34); poke(16'h1003, 8'h12);
        poke(16'h0020, 8'h80); poke(16'h0030, 8'h01); poke(16'h0031, 8'h80);
        poke(16'hFFFE, 8'hAA); poke(16'hFFFF, 8'hBB); poke(16'h0000, 8'hCC); poke(16'h0001, 8'hDD);
        poke(16'h0002, 8'($urandom)); poke(16'h0003, 8'($urandom));
        poke(16'hFFFC, 8'($urandom)); poke(16'hFFFD, 8'($urandom));
        for (int i = 0; i < 16; i++) poke(16'h3000 + 16'(i), 8'($urandom));
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_req", 32'(mem_request_o), 32'd0);
        check("rst_wr", 32'(mem_write_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", 32'(mem_wdata_o), 32'd0);

        // LW, no stalls
        run_op(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 64'h0, 64'h0, dc, rd);
        for (int k = 0; k < 4; k++) begin
            check("lw_req", 32'(log_req[k + 1]), 32'd1);
            check("lw_addr", log_addr[k + 1], 32'h1000 + 32'(k));
        end
        check("lw_drain_req", 32'(log_req[5]), 32'd0);
        check("lw_done_cyc", 32'(dc), 32'd6);
        check("lw_rdata", rd, 32'h12345678);

        run_op(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 64'h0, 64'h0, dc, rd);
        check("lb_done_cyc", 32'(dc), 32'd3);
        check("lb_rdata", rd, 32'hFFFFFF80);
        run_op(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 64'h0, 64'h0, dc, rd);
        check("lbu_rdata", rd, 32'h00000080);
        run_op(1'b0, 2'd1, 1'b0, 32'h30, 32'h0, 64'h0, 64'h0, dc, rd);
        check("lhu_rdata", rd, 32'h00008001);
        run_op(1'b0, 2'd1, 1'b1, 32'h30, 32'h0, 64'h0, 64'h0, dc, rd);
        check("lh_rdata", rd, 32'hFFFF8001);

        // SH to an odd address
        run_op(1'b1, 2'd1, 1'b0, 32'h2001, 32'h0000ABCD, 64'h0, 64'h0, dc, rd);
        check("sh_wr1", 32'(log_wr[1]), 32'd1);
        check("sh_addr1", log_addr[1], 32'h2001);
        check("sh_wd1", 32'(log_wd[1]), 32'hCD);
        check("sh_addr2", log_addr[2], 32'h2002);
        check("sh_wd2", 32'(log_wd[2]), 32'hAB);
        check("sh_done_cyc", 32'(dc), 32'd3);
        @(negedge clk);
        check("sh_ram0", 32'(ram[16'h2001]), 32'hCD);
        check("sh_ram1", 32'(ram[16'h2002]), 32'hAB);

        // LW with grant low in cycles 2-3
        run_op(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 64'h0C, 64'h0, dc, rd);
        check("gnt_addr2", log_addr[2], 32'h1001);
        check("gnt_addr3", log_addr[3], 32'h1001);
        check("gnt_addr4", log_addr[4], 32'h1001);
        check("gnt_done_cyc", 32'(dc), 32'd8);
        check("gnt_rdata", rd, 32'h12345678);

        // LW wrapping past the top of the address space
        run_op(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 64'h0, 64'h0, dc, rd);
        check("wrap_addr1", log_addr[1], 32'hFFFFFFFE);
        check("wrap_addr2", log_addr[2], 32'hFFFFFFFF);
        check("wrap_addr3", log_addr[3], 32'h00000000);
        check("wrap_addr4", log_addr[4], 32'h00000001);
        check("wrap_rdata", rd, 32'hDDCCBBAA);

        // rdy low in the cycle after byte 1 is issued
        run_op(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 64'h0, 64'h08, dc, rd);
        check("rdy_reissue", log_addr[4], 32'h1001);
        check("rdy_done_cyc", 32'(dc), 32'd8);
        check("rdy_rdata", rd, 32'h12345678);

        // rst asserted in cycle 3 of an LW
        @(posedge clk); #1;
        req_i = 1'b1; write_i = 1'b0; size_i = 2'd2; signed_i = 1'b0; addr_i = 32'h1000;
        mem_grant_i = 1'b1;
        @(posedge clk); #1; req_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check("mrst_busy", 32'(busy_o), 32'd0);
        check("mrst_req", 32'(mem_request_o), 32'd0);
        check("mrst_addr", mem_addr_o, 32'd0);
        check("mrst_rdata", rdata_o, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mrst_no_done", 32'(done_o), 32'd0);
        end
        @(posedge clk); #1; rst = 1'b0;
        run_op(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 64'h0, 64'h0, dc, rd);
        check("mrst_after_cyc", 32'(dc), 32'd6);
        check("mrst_after_rdata", rd, 32'h12345678);

        // Randomized mix against the reference memory
        for (int n = 0; n < 40; n++) begin
            logic        wr, sg, quiet, ok;
            logic [1:0]  sz;
            logic [31:0] a, wd, expv, off, ak;
            logic [63:0] gm, rm;
            int          nb;
            wr = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                              : 32'h3000 + $urandom_range(0, 12);
            wd = $urandom;
            nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            quiet = ($urandom_range(0, 3) == 0);
            gm = '0; rm = '0;
            if (!quiet) begin
                for (int b = 1; b <= 20; b++) begin
                    if ($urandom_range(0, 3) == 0) gm[b] = 1'b1;
                    if ($urandom_range(0, 9) == 0) rm[b] = 1'b1;
                end
            end
            expv = ref_load(a, nb, sg);
            run_op(wr, sz, sg, a, wd, gm, rm, dc, rd);
            if (wr) begin
                for (int k = 0; k < nb; k++) begin
                    ak = a + k;
                    ref_mem[ak[15:0]] = wd[8 * k +: 8];
                end
            end else begin
                check("rnd_load", rd, expv);
            end
            if (quiet) check("rnd_latency", 32'(dc), 32'(nb + (wr ? 1 : 2)));
            ok = 1'b0;
            for (int c = 1; c < 64; c++) if (log_req[c]) ok = 1'b1;
            for (int c = 1; c < 64; c++) begin
                if (log_req[c]) begin
                    off = log_addr[c] - a;
                    if (off >= 32'(nb)) ok = 1'b0;
                    else begin
                        if (log_wr[c] !== wr) ok = 1'b0;
                        if (wr && log_wd[c] !== wd[8 * off[1:0] +: 8]) ok = 1'b0;
                    end
                end
            end
            check("rnd_byte_stream", 32'(ok), 32'd1);
        end

        @(negedge clk);
        for (int i = 0; i < 16; i++)
            check("ram_window", 32'(ram[16'h3000 + 16'(i)]), 32'(ref_mem[16'h3000 + 16'(i)]));
        for (int i = 0; i < 8; i++)
            check("ram_wrap", 32'(ram[16'hFFFC + 16'(i)]), 32'(ref_mem[16'hFFFC + 16'(i)]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
